muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_step.sv | 32 +++
 rtl/muldiv_seq.sv | 170 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the sequential multiply/divide unit.
package muldiv_pkg;
  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MLAL = 2'b01,
    OP_MLS  = 2'b10,
    OP_DIV  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;
endpackage

// File: rtl/muldiv_step.sv
// One iteration: shift-add multiply step, or restoring shift-subtract divide step.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_rs;
  logic [WIDTH:0] w_diff;
  logic           w_qbit;

  // Multiply: hi accumulates, lo holds the multiplier shifting out LSB-first.
  assign w_sum  = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_m} : {(WIDTH+1){1'b0}});
  // Divide: hi is the partial remainder, lo shifts dividend out / quotient in.
  assign w_rs   = {i_hi, i_lo[WIDTH-1]};
  assign w_diff = w_rs - {1'b0, i_m};
  assign w_qbit = ~w_diff[WIDTH];

  always_comb begin
    o_hi = w_sum[WIDTH:1];
    o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
    if (i_div) begin
      o_hi = w_qbit ? w_diff[WIDTH-1:0] : w_rs[WIDTH-1:0];
      o_lo = {i_lo[WIDTH-2:0], w_qbit};
    end
  end
endmodule

// File: rtl/muldiv_seq.sv
// Sequential multiply / multiply-accumulate / multiply-subtract / divide unit.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             is_unsigned,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [1:0]       flags
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           r_state;
  logic [CW-1:0]    r_cnt;
  op_e              r_op;
  logic             r_uns;
  logic [WIDTH-1:0] r_a, r_b, r_c, r_d;
  logic [WIDTH-1:0] r_hi, r_lo, r_m;
  logic             r_sgn, r_rsgn;
  logic             r_busy, r_done;
  logic [WIDTH-1:0] r_res_lo, r_res_hi;
  logic [1:0]       r_flags;

  logic             w_a_neg, w_b_neg, w_is_div, w_wide;
  logic [WIDTH-1:0] w_abs_a, w_abs_b;
  logic [WIDTH-1:0] w_hi_n, w_lo_n;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0] w_quot, w_rem;
  logic [2*WIDTH-1:0] w_fin;
  logic [1:0]       w_flags;

  assign w_is_div = (r_op == OP_DIV);
  assign w_a_neg  = ~r_uns & r_a[WIDTH-1];
  assign w_b_neg  = ~r_uns & r_b[WIDTH-1];
  assign w_abs_a  = w_a_neg ? (~r_a + 1'b1) : r_a;
  assign w_abs_b  = w_b_neg ? (~r_b + 1'b1) : r_b;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_div (w_is_div),
    .i_hi  (r_hi),
    .i_lo  (r_lo),
    .i_m   (r_m),
    .o_hi  (w_hi_n),
    .o_lo  (w_lo_n)
  );

  // Sign fix-up: product/quotient take the operand sign, remainder the dividend's.
  assign w_prod_s = r_sgn ? (~{r_hi, r_lo} + 1'b1) : {r_hi, r_lo};
  assign w_quot   = r_sgn ? (~r_lo + 1'b1) : r_lo;
  assign w_rem    = r_rsgn ? (~r_hi + 1'b1) : r_hi;
  assign w_wide   = (r_op == OP_MUL) || (r_op == OP_MLAL);

  always_comb begin
    w_fin = w_prod_s;
    case (r_op)
      OP_MUL:  w_fin = w_prod_s;
      OP_MLAL: w_fin = w_prod_s + {r_d, r_c};
      OP_MLS:  w_fin = {{WIDTH{1'b0}}, r_c - w_prod_s[WIDTH-1:0]};
      OP_DIV:  w_fin = {w_rem, w_quot};
      default: w_fin = w_prod_s;
    endcase
  end

  assign w_flags = w_wide ? {w_fin[2*WIDTH-1], (w_fin == '0)}
                          : {w_fin[WIDTH-1], (w_fin[WIDTH-1:0] == '0)};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_op     <= OP_MUL;
      r_uns    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_d      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_m      <= '0;
      r_sgn    <= 1'b0;
      r_rsgn   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_res_lo <= '0;
      r_res_hi <= '0;
      r_flags  <= 2'b01;
    end else begin
      r_done <= 1'b0;
      if (flush && (r_state != ST_IDLE)) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start && !flush) begin
              r_op    <= op_e'(op);
              r_uns   <= is_unsigned;
              r_a     <= a;
              r_b     <= b;
              r_c     <= c;
              r_d     <= d;
              r_busy  <= 1'b1;
              r_state <= ST_PREP;
            end
          end
          ST_PREP: begin
            r_sgn  <= w_a_neg ^ w_b_neg;
            r_rsgn <= w_a_neg;
            r_hi   <= '0;
            r_cnt  <= '0;
            r_lo   <= w_is_div ? w_abs_a : w_abs_b;
            r_m    <= w_is_div ? w_abs_b : w_abs_a;
            if (w_is_div && (r_b == '0)) begin
              r_res_lo <= '0;
              r_res_hi <= '0;
              r_flags  <= 2'b01;
              r_done   <= 1'b1;
              r_state  <= ST_DONE;
            end else begin
              r_state <= ST_ITER;
            end
          end
          ST_ITER: begin
            r_hi <= w_hi_n;
            r_lo <= w_lo_n;
            if (r_cnt == CW'(WIDTH-1)) begin
              r_cnt   <= '0;
              r_state <= ST_FIX;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_FIX: begin
            r_res_lo <= w_fin[WIDTH-1:0];
            r_res_hi <= w_fin[2*WIDTH-1:WIDTH];
            r_flags  <= w_flags;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end
          ST_DONE: begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign stall     = (start && (r_state != ST_IDLE)) || r_busy;
  assign result_lo = r_res_lo;
  assign result_hi = r_res_hi;
  assign flags     = r_flags;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed vector bench for muldiv_seq, plus flush / reset / busy-start sequences.
module tb_muldiv_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic        is_unsigned;
  logic [31:0] a, b, c, d;
  logic        flush;
  logic        busy, stall, done;
  logic [31:0] result_lo, result_hi;
  logic [1:0]  flags;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .is_unsigned(is_unsigned),
    .a(a), .b(b), .c(c), .d(d), .flush(flush),
    .busy(busy), .stall(stall), .done(done),
    .result_lo(result_lo), .result_hi(result_hi), .flags(flags)
  );

  typedef struct {
    string       nm;
    logic [1:0]  op;
    logic        uns;
    logic [31:0] a, b, c, d;
    logic [31:0] lo, hi;
    logic [1:0]  fl;
    int          cyc;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int cyc;
    @(negedge clk);
    start = 1'b1; op = v.op; is_unsigned = v.uns;
    a = v.a; b = v.b; c = v.c; d = v.d;
    @(negedge clk);
    start = 1'b0;
    // scramble operands: the operation in flight must not see them
    a = $urandom; b = $urandom; c = $urandom; d = $urandom;
    op = 2'($urandom); is_unsigned = ~v.uns;
    cyc = 1;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk({v.nm, "_cyc"}, 64'(cyc), 64'(v.cyc));
    chk({v.nm, "_lo"}, 64'(result_lo), 64'(v.lo));
    chk({v.nm, "_hi"}, 64'(result_hi), 64'(v.hi));
    chk({v.nm, "_flags"}, 64'(flags), 64'(v.fl));
    chk({v.nm, "_busy"}, 64'(busy), 64'd1);
    @(negedge clk);
    chk({v.nm, "_pulse"}, 64'(done), 64'd0);
  endtask

  task automatic setv(input int i, input string nm, input logic [1:0] o, input logic u,
                      input logic [31:0] a_, b_, c_, d_, lo, hi, input logic [1:0] fl,
                      input int cyc);
    vt[i].nm = nm; vt[i].op = o; vt[i].uns = u;
    vt[i].a = a_; vt[i].b = b_; vt[i].c = c_; vt[i].d = d_;
    vt[i].lo = lo; vt[i].hi = hi; vt[i].fl = fl; vt[i].cyc = cyc;
  endtask

  initial begin
    int seen;
    int stall_lo;
    vec_t v;

    setv(0,  "umul_max2",  2'b00, 1, 32'hFFFFFFFF, 32'd2, 0, 0, 32'hFFFFFFFE, 32'd1, 2'b00, 35);
    setv(1,  "smlal",      2'b01, 0, -32'sd3, 32'd7, 32'd100, 32'd0, 32'd79, 32'd0, 2'b00, 35);
    setv(2,  "sdiv_m7_2",  2'b11, 0, -32'sd7, 32'd2, 0, 0, 32'hFFFFFFFD, 32'hFFFFFFFF, 2'b10, 35);
    setv(3,  "div0",       2'b11, 0, 32'd123, 32'd0, 0, 0, 32'd0, 32'd0, 2'b01, 2);
    setv(4,  "sdiv_ovf",   2'b11, 0, 32'h80000000, 32'hFFFFFFFF, 0, 0, 32'h80000000, 32'd0, 2'b10, 35);
    setv(5,  "smul_m1m1",  2'b00, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'd1, 32'd0, 2'b00, 35);
    setv(6,  "smul_m2_3",  2'b00, 0, -32'sd2, 32'd3, 0, 0, 32'hFFFFFFFA, 32'hFFFFFFFF, 2'b10, 35);
    setv(7,  "udiv_100_7", 2'b11, 1, 32'd100, 32'd7, 0, 0, 32'd14, 32'd2, 2'b00, 35);
    setv(8,  "sdiv_7_m2",  2'b11, 0, 32'd7, -32'sd2, 0, 0, 32'hFFFFFFFD, 32'd1, 2'b10, 35);
    setv(9,  "mul_zero",   2'b00, 0, 32'd0, 32'h12345678, 0, 0, 32'd0, 32'd0, 2'b01, 35);
    setv(10, "umlal_max",  2'b01, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h00000002, 32'hFFFFFFFE, 2'b10, 35);
    setv(11, "udiv_max_1", 2'b11, 1, 32'hFFFFFFFF, 32'd1, 0, 0, 32'hFFFFFFFF, 32'd0, 2'b10, 35);
    setv(12, "umls_neg",   2'b10, 1, 32'd3, 32'd4, 32'd5, 32'd0, 32'hFFFFFFF9, 32'd0, 2'b10, 35);
    setv(13, "sdiv_m8_m3", 2'b11, 0, -32'sd8, -32'sd3, 0, 0, 32'd2, 32'hFFFFFFFE, 2'b00, 35);
    setv(14, "udiv_0_5",   2'b11, 1, 32'd0, 32'd5, 0, 0, 32'd0, 32'd0, 2'b01, 35);

    reset = 1'b1; start = 1'b0; op = 2'b00; is_unsigned = 1'b0;
    a = '0; b = '0; c = '0; d = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_res", {result_hi, result_lo}, 0);
    chk("rst_flags", 64'(flags), 64'd1);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 15; i++) run_op(vt[i]);

    // flush mid-MUL, then MLS must complete normally
    @(negedge clk);
    start = 1'b1; op = 2'b00; is_unsigned = 1'b1; a = 32'd5; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    repeat (9) begin
      @(negedge clk);
      if (done) seen++;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 0);
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("flush_nodone", 64'(seen), 0);
    chk("flush_keep_lo", 64'(result_lo), 64'd0);
    v.nm = "mls_after_flush"; v.op = 2'b10; v.uns = 1'b0; v.a = 32'd2; v.b = 32'd3;
    v.c = 32'd10; v.d = 32'd0; v.lo = 32'd4; v.hi = 32'd0; v.fl = 2'b00; v.cyc = 35;
    run_op(v);

    // flush together with start in IDLE drops the request
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
    chk("idle_stall", 64'(stall), 0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flushstart_busy", 64'(busy), 0);

    // start during busy is ignored; stall covers the whole busy window
    @(negedge clk);
    start = 1'b1; op = 2'b00; is_unsigned = 1'b1; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    stall_lo = 0; seen = 0;
    for (int k = 0; k < 60; k++) begin
      if (k == 5 || k == 6) begin
        start = 1'b1; op = 2'b11; a = 32'd77; b = 32'd7;
      end else begin
        start = 1'b0;
      end
      #1;
      if (busy && !stall) stall_lo++;
      if (done) begin
        seen++;
        chk("busy_start_lo", 64'(result_lo), 64'd12);
      end
      @(negedge clk);
    end
    chk("busy_start_ndone", 64'(seen), 64'd1);
    chk("busy_stall", 64'(stall_lo), 0);

    // reset mid-ITER aborts, with a second start pulse during busy
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd8;
    @(negedge clk);
    start = 1'b0;
    stall_lo = 0;
    for (int k = 0; k < 8; k++) begin
      start = (k == 3);
      #1;
      if (!stall) stall_lo++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("rmid_stall", 64'(stall_lo), 0);
    reset = 1'b1;
    #1;
    chk("rmid_busy", 64'(busy), 0);
    chk("rmid_done", 64'(done), 0);
    chk("rmid_res", {result_hi, result_lo}, 0);
    chk("rmid_flags", 64'(flags), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("rmid_quiet", 64'(seen), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule
